// File: rtl/agendador_rega.sv
// Two-zone irrigation scheduler sharing one pump: grants one valve per slot,
// alternates on ties, and inserts a dead time between slots, paced by a slow external clock.
module agendador_rega #(
  parameter int DURACAO = 8,
  parameter int PAUSA   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_Reduzido,
  input  logic [1:0] req,
  output logic [1:0] valvula,
  output logic       bomba,
  output logic       ocupado,
  output logic [3:0] restante,
  output logic [1:0] estado
);

  localparam logic [3:0] DUR_EFF = (DURACAO == 0) ? 4'd1 : 4'(DURACAO);
  localparam logic [3:0] PAU     = 4'(PAUSA);

  typedef enum logic [1:0] {
    ST_LIVRE   = 2'd0,
    ST_REGANDO = 2'd1,
    ST_PAUSA   = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [3:0] restante_nx;
  logic [1:0] valvula_nx;
  logic       ultimo, ultimo_nx;
  logic       winner;
  logic       fim;
  logic       sync1, sync2, hist;
  logic       tick;

  // clock_Reduzido is unrelated to clock: resynchronize, then detect rising edges only
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= clock_Reduzido;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign tick = sync2 & ~hist;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_LIVRE;
      restante <= 4'd0;
      valvula  <= 2'b00;
      bomba    <= 1'b0;
      ultimo   <= 1'b1;
    end else begin
      state    <= state_nx;
      restante <= restante_nx;
      valvula  <= valvula_nx;
      bomba    <= |valvula_nx;
      ultimo   <= ultimo_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    restante_nx = restante;
    valvula_nx  = valvula;
    ultimo_nx   = ultimo;
    winner      = 1'b0;
    fim         = 1'b0;
    case (state)
      ST_LIVRE: begin
        if (req != 2'b00) begin
          winner      = (req == 2'b11) ? ~ultimo : req[1];
          state_nx    = ST_REGANDO;
          restante_nx = DUR_EFF;
          valvula_nx  = winner ? 2'b10 : 2'b01;
          ultimo_nx   = winner;
        end
      end
      ST_REGANDO: begin
        // ultimo is the zone currently granted; losing its request ends the slot
        fim = !req[ultimo] || (tick && (restante <= 4'd1));
        if (fim) begin
          valvula_nx = 2'b00;
          if (PAU == 4'd0) begin
            state_nx    = ST_LIVRE;
            restante_nx = 4'd0;
          end else begin
            state_nx    = ST_PAUSA;
            restante_nx = PAU;
          end
        end else if (tick) begin
          restante_nx = restante - 4'd1;
        end
      end
      ST_PAUSA: begin
        if (tick) begin
          if (restante <= 4'd1) begin
            state_nx    = ST_LIVRE;
            restante_nx = 4'd0;
          end else begin
            restante_nx = restante - 4'd1;
          end
        end
      end
      default: begin
        state_nx    = ST_LIVRE;
        restante_nx = 4'd0;
        valvula_nx  = 2'b00;
      end
    endcase
  end

  assign ocupado = (state != ST_LIVRE);
  assign estado  = state;

endmodule

// File: tb/tb_agendador_rega.sv
// Directed bench for agendador_rega: expected output snapshots are queued by the
// stimulus and consumed by monitors each time a DUT's outputs change.
module tb_agendador_rega;

  logic       clk = 1'b0;
  logic       rst;
  logic       cr;
  logic [1:0] req_a, req_b;
  logic [1:0] va, vb, ea, eb;
  logic       ba, bb, oa, ob;
  logic [3:0] ra, rb;

  int checks = 0;
  int errors = 0;
  logic mon_on  = 1'b0;
  logic rand_on = 1'b0;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic [9:0] snap_a, snap_b;

  always #5 clk = ~clk;

  agendador_rega #(.DURACAO(3), .PAUSA(2)) dut_a (
    .clock(clk), .reset(rst), .clock_Reduzido(cr), .req(req_a),
    .valvula(va), .bomba(ba), .ocupado(oa), .restante(ra), .estado(ea)
  );

  agendador_rega #(.DURACAO(2), .PAUSA(0)) dut_b (
    .clock(clk), .reset(rst), .clock_Reduzido(cr), .req(req_b),
    .valvula(vb), .bomba(bb), .ocupado(ob), .restante(rb), .estado(eb)
  );

  assign snap_a = {ea, va, ba, oa, ra};
  assign snap_b = {eb, vb, bb, ob, rb};

  // state code: 0 LIVRE, 1 REGANDO, 2 PAUSA; pump follows any open valve, busy when not LIVRE
  function automatic logic [9:0] mk(input logic [1:0] e, input logic [1:0] v, input logic [3:0] r);
    return {e, v, |v, (e != 2'd0), r};
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [1:0] e, input logic [1:0] v, input logic [3:0] r);
    exp_a.push_back(mk(e, v, r));
  endtask

  task automatic push_b(input logic [1:0] e, input logic [1:0] v, input logic [3:0] r);
    exp_b.push_back(mk(e, v, r));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slow(input int n);
    repeat (n) begin
      cr = 1'b1; cyc(8);
      cr = 1'b0; cyc(8);
    end
  endtask

  initial begin : mon_a
    logic [9:0] prev;
    prev = 10'd0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        checks++;
        if (va == 2'b11 || ba !== |va) begin
          errors++;
          $display("FAIL inv_a valvula %b bomba %b required one-hot and bomba==|valvula", va, ba);
        end
        if (!rand_on && snap_a !== prev) begin
          if (exp_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_extra got %h expected no change", snap_a);
          end else begin
            chk("a_seq", snap_a, exp_a.pop_front());
          end
        end
        prev = snap_a;
      end
    end
  end

  initial begin : mon_b
    logic [9:0] prev;
    prev = 10'd0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        checks++;
        if (vb == 2'b11 || bb !== |vb) begin
          errors++;
          $display("FAIL inv_b valvula %b bomba %b required one-hot and bomba==|valvula", vb, bb);
        end
        if (!rand_on && snap_b !== prev) begin
          if (exp_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_extra got %h expected no change", snap_b);
          end else begin
            chk("b_seq", snap_b, exp_b.pop_front());
          end
        end
        prev = snap_b;
      end
    end
  end

  initial begin
    rst = 1'b1; cr = 1'b0; req_a = 2'b00; req_b = 2'b00;
    cyc(3);
    chk("reset_a", snap_a, mk(2'd0, 2'b00, 4'd0));
    chk("reset_b", snap_b, mk(2'd0, 2'b00, 4'd0));
    rst = 1'b0;
    cyc(2);
    chk("idle_a", snap_a, mk(2'd0, 2'b00, 4'd0));
    mon_on = 1'b1;

    // tie after reset: zone 0 first, then zone 1 after the pause
    push_a(1, 2'b01, 3); push_a(1, 2'b01, 2); push_a(1, 2'b01, 1);
    push_a(2, 2'b00, 2); push_a(2, 2'b00, 1); push_a(0, 2'b00, 0);
    push_a(1, 2'b10, 3); push_a(1, 2'b10, 2); push_a(1, 2'b10, 1);
    push_a(2, 2'b00, 2); push_a(2, 2'b00, 1); push_a(0, 2'b00, 0);
    req_a = 2'b11; cyc(2);
    slow(8);
    req_a = 2'b00;
    slow(2);

    // early release landing on the same edge as a tick
    push_a(1, 2'b01, 3); push_a(1, 2'b01, 2);
    push_a(2, 2'b00, 2); push_a(2, 2'b00, 1); push_a(0, 2'b00, 0);
    req_a = 2'b01; cyc(2);
    slow(1);
    cr = 1'b1; cyc(2);
    req_a = 2'b00; cyc(6);
    cr = 1'b0; cyc(8);
    slow(2);

    // single requester held: repeated service with a pause between slots
    push_a(1, 2'b01, 3); push_a(1, 2'b01, 2); push_a(1, 2'b01, 1);
    push_a(2, 2'b00, 2); push_a(2, 2'b00, 1); push_a(0, 2'b00, 0);
    push_a(1, 2'b01, 3); push_a(1, 2'b01, 2);
    push_a(2, 2'b00, 2); push_a(2, 2'b00, 1); push_a(0, 2'b00, 0);
    req_a = 2'b01; cyc(2);
    slow(6);
    req_a = 2'b00; cyc(2);
    slow(2);

    // tick latency: a rise is acted on at the 3rd edge, once only
    push_a(1, 2'b01, 3); push_a(1, 2'b01, 2);
    req_a = 2'b01; cyc(2);
    cr = 1'b1;
    cyc(1); chk("tick_e1", {6'd0, ra}, {6'd0, 4'd3});
    cyc(1); chk("tick_e2", {6'd0, ra}, {6'd0, 4'd3});
    cyc(1); chk("tick_e3", {6'd0, ra}, {6'd0, 4'd2});
    cyc(5); chk("tick_once", {6'd0, ra}, {6'd0, 4'd2});
    cr = 1'b0; cyc(8);

    // reset mid-slot with restante=2, then clock_Reduzido high across deassertion
    push_a(0, 2'b00, 0);
    rst = 1'b1; cyc(1);
    chk("reset_mid", snap_a, mk(2'd0, 2'b00, 4'd0));
    cr = 1'b1; cyc(2);
    push_a(1, 2'b01, 3); push_a(1, 2'b01, 2);
    rst = 1'b0;
    cyc(1); chk("rst_tick_e1", {6'd0, ra}, {6'd0, 4'd3});
    cyc(1); chk("rst_tick_e2", {6'd0, ra}, {6'd0, 4'd3});
    cyc(1); chk("rst_tick_e3", {6'd0, ra}, {6'd0, 4'd2});
    cyc(8); chk("rst_tick_once", {6'd0, ra}, {6'd0, 4'd2});
    push_a(2, 2'b00, 2); push_a(2, 2'b00, 1); push_a(0, 2'b00, 0);
    req_a = 2'b00; cyc(2);
    cr = 1'b0; cyc(8);
    slow(2);

    // zero pause: straight back to LIVRE, other zone granted on the next edge
    push_b(1, 2'b01, 2); push_b(1, 2'b01, 1); push_b(0, 2'b00, 0);
    push_b(1, 2'b10, 2); push_b(1, 2'b10, 1); push_b(0, 2'b00, 0);
    req_b = 2'b11; cyc(2);
    slow(3);
    req_b = 2'b00; cyc(2);
    slow(1);

    cyc(4);
    checks++;
    if (exp_a.size() != 0) begin
      errors++;
      $display("FAIL a_pending got %0d entries expected 0", exp_a.size());
    end
    checks++;
    if (exp_b.size() != 0) begin
      errors++;
      $display("FAIL b_pending got %0d entries expected 0", exp_b.size());
    end

    // random requests and slow clock: only the one-hot/pump invariants are checked
    rand_on = 1'b1;
    repeat (400) begin
      req_a = 2'($urandom_range(0, 3));
      req_b = 2'($urandom_range(0, 3));
      cr    = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
